// File: rtl/stream_packet_arbiter.sv
// Packet-granular round-robin arbiter for keep/last/valid/ready byte-lane streams.
// A grant is held for a whole packet; a one-entry registered output stage tags every beat with its source.
module stream_packet_arbiter #(
    parameter int T_DATA_WIDTH = 4,
    parameter int KEEP_WIDTH   = 4,
    parameter int N_SRC        = 3,
    localparam int SRC_W       = $clog2(N_SRC)
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic [N_SRC-1:0]                                src_en_i,
    input  logic [N_SRC-1:0][KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [N_SRC-1:0][KEEP_WIDTH-1:0]                s_keep_i,
    input  logic [N_SRC-1:0]                                s_last_i,
    input  logic [N_SRC-1:0]                                s_valid_i,
    output logic [N_SRC-1:0]                                s_ready_o,
    output logic [KEEP_WIDTH-1:0][T_DATA_WIDTH-1:0]         m_data_o,
    output logic [KEEP_WIDTH-1:0]                           m_keep_o,
    output logic                                            m_last_o,
    output logic                                            m_valid_o,
    input  logic                                            m_ready_i,
    output logic [SRC_W-1:0]                                m_src_o,
    output logic                                            busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  grant;
    logic [SRC_W-1:0]  arb_idx;
    logic              arb_found;
    logic [N_SRC-1:0]  req;
    int unsigned       cand;
    logic              grant_ready;
    logic              accept;
    logic              accept_last;

    // Round-robin search starting just after the source that finished last.
    always_comb begin
        req       = s_valid_i & src_en_i;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= N_SRC; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_SRC) begin
                cand = cand - N_SRC;
            end
            if (!arb_found && req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = SRC_W'(cand);
            end
        end
    end

    assign grant_ready = !m_valid_o || m_ready_i;
    assign accept      = (state == GRANT) && s_valid_i[grant] && grant_ready;
    assign accept_last = accept && s_last_i[grant];
    assign busy_o      = (state == GRANT);

    // Only the granted source sees ready, and nothing is ready while reset is asserted.
    always_comb begin
        s_ready_o = '0;
        if (!rst_i && state == GRANT) begin
            s_ready_o[grant] = grant_ready;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (arb_found) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (accept_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            rr_ptr <= SRC_W'(N_SRC - 1);
            grant  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && arb_found) begin
                grant <= arb_idx;
            end
            if (accept_last) begin
                rr_ptr <= grant;
            end
        end
    end

    // Output stage: a push may replace the entry in the same cycle it is popped.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            m_keep_o  <= '0;
            m_last_o  <= 1'b0;
            m_src_o   <= '0;
        end else if (accept) begin
            m_valid_o <= 1'b1;
            m_data_o  <= s_data_i[grant];
            m_keep_o  <= s_keep_i[grant];
            m_last_o  <= s_last_i[grant];
            m_src_o   <= grant;
        end else if (m_ready_i) begin
            m_valid_o <= 1'b0;
        end
    end

    a_ready_onehot : assert property (@(posedge clk_i) $onehot0(s_ready_o));

    a_hold_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (m_valid_o && !m_ready_i) |=> (m_valid_o && $stable(m_data_o) && $stable(m_keep_o)
                                        && $stable(m_last_o) && $stable(m_src_o)));

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Directed scoreboard bench for stream_packet_arbiter: expected beats are queued when
// packets are issued, and a negedge monitor pops and compares every transferred output beat.
module tb_stream_packet_arbiter;

    localparam int TDW = 4;
    localparam int KW  = 4;
    localparam int NS  = 3;
    localparam int SW  = $clog2(NS);

    typedef struct packed {
        logic [KW*TDW-1:0] data;
        logic [KW-1:0]     keep;
        logic              last;
        logic [SW-1:0]     src;
    } beat_t;

    logic                         clk_i = 1'b0;
    logic                         rst_i;
    logic [NS-1:0]                src_en_i;
    logic [NS-1:0][KW-1:0][TDW-1:0] s_data_i;
    logic [NS-1:0][KW-1:0]        s_keep_i;
    logic [NS-1:0]                s_last_i;
    logic [NS-1:0]                s_valid_i;
    logic [NS-1:0]                s_ready_o;
    logic [KW-1:0][TDW-1:0]       m_data_o;
    logic [KW-1:0]                m_keep_o;
    logic                         m_last_o;
    logic                         m_valid_o;
    logic                         m_ready_i;
    logic [SW-1:0]                m_src_o;
    logic                         busy_o;

    int    n_compared   = 0;
    int    n_mismatched = 0;
    int    cycle        = 0;
    bit    sb_en        = 1'b0;
    bit    done_flag;
    int    bad_ready;
    int    c0;
    beat_t sb_q[$];
    int    pop_cycles[$];

    stream_packet_arbiter #(
        .T_DATA_WIDTH(TDW),
        .KEEP_WIDTH  (KW),
        .N_SRC       (NS)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .src_en_i (src_en_i),
        .s_data_i (s_data_i),
        .s_keep_i (s_keep_i),
        .s_last_i (s_last_i),
        .s_valid_i(s_valid_i),
        .s_ready_o(s_ready_o),
        .m_data_o (m_data_o),
        .m_keep_o (m_keep_o),
        .m_last_o (m_last_o),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .m_src_o  (m_src_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cycle <= cycle + 1;

    function automatic logic [15:0] gen_data(input int src, input int pkt, input int beat);
        return {4'(src + 1), 4'(pkt), 4'(beat), 4'hA};
    endfunction

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push_pkt(input int src, input int pkt, input int nbeats, input logic [3:0] last_keep);
        beat_t b;
        for (int i = 0; i < nbeats; i++) begin
            b.data = gen_data(src, pkt, i);
            b.keep = (i == nbeats - 1) ? last_keep : 4'hF;
            b.last = (i == nbeats - 1);
            b.src  = SW'(src);
            sb_q.push_back(b);
        end
    endtask

    // Drives one packet on a source; each beat waits for its handshake within a cycle budget.
    task automatic apply_stimulus(input int src, input int pkt, input int nbeats, input logic [3:0] last_keep);
        for (int i = 0; i < nbeats; i++) begin
            int waited = 0;
            bit hs = 1'b0;
            s_data_i[src]  = gen_data(src, pkt, i);
            s_keep_i[src]  = (i == nbeats - 1) ? last_keep : 4'hF;
            s_last_i[src]  = (i == nbeats - 1);
            s_valid_i[src] = 1'b1;
            while (!hs && waited < 200) begin
                @(negedge clk_i);
                hs = s_ready_o[src];
                @(posedge clk_i);
                #1;
                waited++;
            end
            if (!hs) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL handshake_timeout: src %0d pkt %0d beat %0d got no ready, expected ready within 200 cycles", src, pkt, i);
                break;
            end
        end
        s_valid_i[src] = 1'b0;
        s_last_i[src]  = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic drain_and_check(input string name);
        repeat (6) @(posedge clk_i);
        #1;
        check_output(name, 64'(sb_q.size()), 64'd0);
        sb_q.delete();
    endtask

    // Monitor: compares transferred beats, hold stability under stall, and ready while full.
    initial begin : monitor
        bit    prev_stall = 1'b0;
        beat_t held;
        beat_t act;
        forever begin
            @(negedge clk_i);
            act = '{data: m_data_o, keep: m_keep_o, last: m_last_o, src: m_src_o};
            if (!rst_i && sb_en) begin
                if (prev_stall) begin
                    check_output("hold_stable", {m_valid_o, act}, {1'b1, held});
                end
                if (m_valid_o && !m_ready_i) begin
                    check_output("ready_while_full", 64'(s_ready_o), 64'd0);
                end
                if (m_valid_o && m_ready_i) begin
                    pop_cycles.push_back(cycle);
                    if (sb_q.size() == 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no beat", act);
                    end else begin
                        check_output("beat", 64'(act), 64'(sb_q.pop_front()));
                    end
                end
                prev_stall = m_valid_o && !m_ready_i;
                held       = act;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        rst_i     = 1'b1;
        src_en_i  = 3'b111;
        s_data_i  = '0;
        s_keep_i  = '0;
        s_last_i  = '0;
        s_valid_i = '0;
        m_ready_i = 1'b1;
        do_reset();

        @(negedge clk_i);
        check_output("rst_m_valid", 64'(m_valid_o), 64'd0);
        check_output("rst_m_data", 64'(m_data_o), 64'd0);
        check_output("rst_m_keep", 64'(m_keep_o), 64'd0);
        check_output("rst_m_last", 64'(m_last_o), 64'd0);
        check_output("rst_m_src", 64'(m_src_o), 64'd0);
        check_output("rst_busy", 64'(busy_o), 64'd0);
        check_output("rst_s_ready", 64'(s_ready_o), 64'd0);
        sb_en = 1'b1;

        // Test 1: single source, 3 beats, latency 2 cycles from valid.
        $display("[TB] test 1: src0 3-beat packet");
        @(posedge clk_i);
        #1;
        pop_cycles.delete();
        push_pkt(0, 1, 3, 4'h3);
        c0 = cycle;
        apply_stimulus(0, 1, 3, 4'h3);
        drain_and_check("t1_sb_empty");
        check_output("t1_pop_count", 64'(pop_cycles.size()), 64'd3);
        if (pop_cycles.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check_output($sformatf("t1_beat%0d_cycle", i), 64'(pop_cycles[i]), 64'(c0 + 2 + i));
            end
        end

        // Test 2: all sources, 1-beat packets, round-robin 0,1,2,0,1,2 with 2-cycle spacing.
        $display("[TB] test 2: round-robin of 1-beat packets");
        do_reset();
        pop_cycles.delete();
        push_pkt(0, 2, 1, 4'hF);
        push_pkt(1, 2, 1, 4'hF);
        push_pkt(2, 2, 1, 4'hF);
        push_pkt(0, 3, 1, 4'hF);
        push_pkt(1, 3, 1, 4'hF);
        push_pkt(2, 3, 1, 4'hF);
        fork
            begin apply_stimulus(0, 2, 1, 4'hF); apply_stimulus(0, 3, 1, 4'hF); end
            begin apply_stimulus(1, 2, 1, 4'hF); apply_stimulus(1, 3, 1, 4'hF); end
            begin apply_stimulus(2, 2, 1, 4'hF); apply_stimulus(2, 3, 1, 4'hF); end
        join
        drain_and_check("t2_sb_empty");
        check_output("t2_pop_count", 64'(pop_cycles.size()), 64'd6);
        if (pop_cycles.size() == 6) begin
            for (int i = 1; i < 6; i++) begin
                check_output($sformatf("t2_gap%0d", i), 64'(pop_cycles[i] - pop_cycles[i-1]), 64'd2);
            end
        end

        // Test 3: src1 4-beat packet, src2 arrives mid-packet and must wait.
        $display("[TB] test 3: no interleave");
        do_reset();
        push_pkt(1, 4, 4, 4'h0);
        push_pkt(2, 4, 1, 4'h5);
        done_flag = 1'b0;
        bad_ready = 0;
        fork
            begin apply_stimulus(1, 4, 4, 4'h0); done_flag = 1'b1; end
            begin repeat (3) @(posedge clk_i); #1; apply_stimulus(2, 4, 1, 4'h5); end
            begin
                while (!done_flag) begin
                    @(negedge clk_i);
                    if (s_ready_o[2]) bad_ready++;
                end
            end
        join
        check_output("t3_src2_ready_early", 64'(bad_ready), 64'd0);
        drain_and_check("t3_sb_empty");

        // Test 4: downstream stall pattern 1,0,0,1 during a src0 packet.
        $display("[TB] test 4: output stall");
        do_reset();
        push_pkt(0, 6, 4, 4'h7);
        fork
            apply_stimulus(0, 6, 4, 4'h7);
            begin
                int w = 0;
                do begin @(negedge clk_i); w++; end while (!m_valid_o && w < 50);
                check_output("t4_first_valid", 64'(m_valid_o), 64'd1);
                @(posedge clk_i); #1; m_ready_i = 1'b0;
                @(negedge clk_i);
                check_output("t4_busy_stalled", 64'(busy_o), 64'd1);
                @(posedge clk_i); #1; m_ready_i = 1'b0;
                @(posedge clk_i); #1; m_ready_i = 1'b1;
            end
        join
        drain_and_check("t4_sb_empty");

        // Test 5: src1 masked, order 0,2,0,2; then mask drop on the granted source mid-packet.
        $display("[TB] test 5: enable mask");
        do_reset();
        src_en_i = 3'b101;
        s_valid_i[1] = 1'b1;
        s_last_i[1]  = 1'b1;
        push_pkt(0, 7, 1, 4'hF);
        push_pkt(2, 7, 1, 4'hF);
        push_pkt(0, 8, 1, 4'hF);
        push_pkt(2, 8, 1, 4'hF);
        done_flag = 1'b0;
        bad_ready = 0;
        fork
            begin
                fork
                    begin apply_stimulus(0, 7, 1, 4'hF); apply_stimulus(0, 8, 1, 4'hF); end
                    begin apply_stimulus(2, 7, 1, 4'hF); apply_stimulus(2, 8, 1, 4'hF); end
                join
                done_flag = 1'b1;
            end
            begin
                while (!done_flag) begin
                    @(negedge clk_i);
                    if (s_ready_o[1]) bad_ready++;
                end
            end
        join
        check_output("t5_src1_ready", 64'(bad_ready), 64'd0);
        drain_and_check("t5a_sb_empty");
        s_valid_i[1] = 1'b0;
        s_last_i[1]  = 1'b0;
        push_pkt(0, 9, 3, 4'hC);
        fork
            apply_stimulus(0, 9, 3, 4'hC);
            begin
                int w = 0;
                do begin @(negedge clk_i); w++; end while (!s_ready_o[0] && w < 50);
                @(posedge clk_i); #1; src_en_i = 3'b100;
            end
        join
        drain_and_check("t5b_sb_empty");
        check_output("t5b_busy_after", 64'(busy_o), 64'd0);
        src_en_i = 3'b111;

        // Test 6: reset for one cycle mid-packet, then search restarts at src0.
        $display("[TB] test 6: reset mid-packet");
        do_reset();
        sb_en = 1'b0;
        s_data_i[0]  = 16'hDEAD;
        s_keep_i[0]  = 4'hF;
        s_last_i[0]  = 1'b0;
        s_valid_i[0] = 1'b1;
        repeat (3) begin @(posedge clk_i); #1; end
        rst_i = 1'b1;
        @(negedge clk_i);
        check_output("t6_ready_in_reset", 64'(s_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        s_valid_i[0] = 1'b0;
        @(negedge clk_i);
        check_output("t6_m_valid", 64'(m_valid_o), 64'd0);
        check_output("t6_busy", 64'(busy_o), 64'd0);
        check_output("t6_s_ready", 64'(s_ready_o), 64'd0);
        sb_en = 1'b1;
        @(posedge clk_i);
        #1;
        push_pkt(0, 10, 1, 4'h1);
        push_pkt(1, 10, 1, 4'h2);
        fork
            apply_stimulus(0, 10, 1, 4'h1);
            apply_stimulus(1, 10, 1, 4'h2);
        join
        drain_and_check("t6_sb_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
